apb_cmd_master: RTL and testbench

APB3 initiator (requester) that turns a simple valid/ready command stream into single APB transfers toward the UART register slaves. It replaces bench-side APB driving with synthesizable RTL, so an on-chip controller can program the UART data, status, control, interrupt, baud-rate and parity registers. It sits between a command source (CPU bridge or sequencer) and the APB PSEL/PENABLE bus of one slave.

---
 rtl/apb_cmd_master_pkg.sv | 20 ++
 rtl/apb_cmd_master_tmo_cnt.sv | 29 ++
 rtl/apb_cmd_master.sv | 132 +++++++++++++
 tb/tb_apb_cmd_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared FSM state type and UART register map used by apb_cmd_master.
package apb_cmd_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;

   // UART register word addresses within one slave window
   localparam logic [9:0] UART_DATA_ADDR   = 10'h000;
   localparam logic [9:0] UART_STATUS_ADDR = 10'h001;
   localparam logic [9:0] UART_CTRL_ADDR   = 10'h002;
   localparam logic [9:0] UART_INT_ADDR    = 10'h003;
   localparam logic [9:0] UART_BAUD_ADDR   = 10'h004;
   localparam logic [9:0] UART_PARITY_ADDR = 10'h005;
   localparam logic [9:0] SLAVE_STRIDE     = 10'h008;

   function automatic logic [9:0] uart_reg_addr(input logic [9:0] slave_idx,
                                                input logic [9:0] reg_off);
      return slave_idx * SLAVE_STRIDE + reg_off;
   endfunction

endpackage

// File: rtl/apb_cmd_master_tmo_cnt.sv
// ACCESS wait-state counter; o_done marks the PREADY-low cycle that hits TMO_CYC.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_tmo_cnt #(
   parameter int TMO_CYC = 16
)(
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_done
);

   localparam logic [7:0] LIMIT = 8'(TMO_CYC - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc)
         r_cnt <= r_cnt + 8'd1;
   end

   // The increment that would reach TMO_CYC is the abort cycle itself
   assign o_done = i_inc && (r_cnt == LIMIT);

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 requester: one valid/ready command becomes one APB transfer plus one response.
// Define APB_TIMEOUT_EN to abort ACCESS after TMO_CYC PREADY-low cycles.
module apb_cmd_master
   import apb_cmd_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = 16
)(
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_tmo,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   apb_state_t        r_state;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_rsp_tmo;
   logic              w_tmo_done;
   logic              w_finish;

`ifdef APB_TIMEOUT_EN
   logic w_tmo_clr;
   logic w_tmo_inc;

   assign w_tmo_clr = (r_state == SETUP);
   assign w_tmo_inc = (r_state == ACCESS) && !PREADY;

   apb_tmo_cnt #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo_cnt (
      .clk    (PCLK),
      .rst    (PRESET),
      .i_clr  (w_tmo_clr),
      .i_inc  (w_tmo_inc),
      .o_done (w_tmo_done)
   );
`else
   assign w_tmo_done = 1'b0;
`endif

   assign w_finish = PREADY || w_tmo_done;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state     <= IDLE;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_tmo   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_psel   <= 1'b1;
                  r_pwrite <= cmd_write;
                  r_paddr  <= cmd_addr;
                  r_pwdata <= cmd_wdata;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               // A timeout wins: slave data/error are meaningless once aborted
               if (w_finish) begin
                  r_rsp_rdata <= (r_pwrite || w_tmo_done) ? '0 : PRDATA;
                  r_rsp_err   <= w_tmo_done || PSLVERR;
                  r_rsp_tmo   <= w_tmo_done;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_pwrite    <= 1'b0;
                  r_paddr     <= '0;
                  r_pwdata    <= '0;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Gated by PRESET so every output reads 0 while reset is held
   assign cmd_ready = (r_state == IDLE) && !PRESET;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign rsp_tmo   = r_rsp_tmo;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed and random transfers against a transaction-level model.
// Expectations follow APB_TIMEOUT_EN when the bench is built with it.
module tb_apb_cmd_master;
   import apb_cmd_pkg::*;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 32;
   localparam int TMO_CYC   = 16;
   localparam int LAT_BOUND = 1100;
`ifdef APB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_tmo;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   int n_checks = 0;
   int n_errors = 0;

   always #5 PCLK = ~PCLK;

   apb_cmd_master #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .rsp_tmo   (rsp_tmo),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete command/response transaction. Must be called just after a
   // falling edge of an IDLE cycle. The slave inserts 'waits' PREADY-low cycles.
   task automatic do_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int waits,
                          input logic [DATA_W-1:0] rdata, input logic slverr,
                          input int rdly);
      logic              exp_tmo;
      int                exp_lat;
      int                exp_pen;
      logic [DATA_W-1:0] exp_rd;
      logic              exp_err;
      int                left;
      int                pen_cnt;
      int                rsp_c;
      logic              bus_ok;

      exp_tmo = TMO_EN && (waits >= TMO_CYC);
      exp_lat = exp_tmo ? 2 + TMO_CYC : 3 + waits;
      exp_pen = exp_tmo ? TMO_CYC : waits + 1;
      exp_rd  = (wr || exp_tmo) ? '0 : rdata;
      exp_err = exp_tmo || slverr;

      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      left      = waits;
      pen_cnt   = 0;
      rsp_c     = 0;
      bus_ok    = 1'b1;

      for (int c = 1; c <= LAT_BOUND && rsp_c == 0; c++) begin
         @(negedge PCLK);
         if (c == 1) begin
            chk("setup_phase", {PSEL, PENABLE, cmd_ready, PWRITE, PADDR, PWDATA},
                {1'b1, 1'b0, 1'b0, wr, addr, wdata});
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = 10'($urandom);
            cmd_wdata = $urandom;
         end
         if (rsp_valid) begin
            rsp_c = c;
         end else if (PENABLE) begin
            pen_cnt++;
            if (!(PSEL && PWRITE === wr && PADDR === addr && PWDATA === wdata))
               bus_ok = 1'b0;
            if (left > 0) begin
               PREADY  = 1'b0;
               PRDATA  = $urandom;
               PSLVERR = 1'($urandom);
               left--;
            end else begin
               PREADY  = 1'b1;
               PRDATA  = rdata;
               PSLVERR = slverr;
            end
         end else begin
            PREADY  = 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
         end
      end

      chk("rsp_arrived", 64'(rsp_c != 0), 64'(1));
      chk("rsp_latency", 64'(rsp_c), 64'(exp_lat));
      chk("penable_cycles", 64'(pen_cnt), 64'(exp_pen));
      chk("bus_stable", 64'(bus_ok), 64'(1));
      chk("rsp_fields", {rsp_rdata, rsp_err, rsp_tmo}, {exp_rd, exp_err, exp_tmo});
      chk("bus_idle_in_resp", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'(0));

      // A pending command during backpressure must not be taken
      rsp_ready = (rdly == 0);
      cmd_valid = (rdly != 0);
      for (int k = 0; k < rdly; k++) begin
         @(negedge PCLK);
         chk("rsp_hold", {rsp_valid, rsp_rdata, rsp_err, rsp_tmo, cmd_ready, PSEL},
             {1'b1, exp_rd, exp_err, exp_tmo, 1'b0, 1'b0});
      end
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("rsp_handshake", {rsp_valid, cmd_ready}, 64'(2'b01));
      rsp_ready = 1'b0;
      $display("xfer wr=%0d addr=0x%03h wdata=0x%08h waits=%0d rdly=%0d -> rdata=0x%08h err=%0d tmo=%0d lat=%0d",
               wr, addr, wdata, waits, rdly, rsp_rdata, rsp_err, rsp_tmo, rsp_c);
   endtask

   initial begin
      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;

      repeat (2) @(negedge PCLK);
      chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_tmo, PSEL, PENABLE, PWRITE, PADDR},
          64'(0));
      chk("reset_data", {rsp_rdata, PWDATA}, 64'(0));
      PRESET = 1'b0;
      #1;
      chk("ready_after_reset", 64'(cmd_ready), 64'(1));

      do_xfer(1'b1, UART_CTRL_ADDR, 32'h3f, 0, 32'h0, 1'b0, 0);
      do_xfer(1'b0, UART_STATUS_ADDR, 32'h0, 3, 32'hA5, 1'b0, 0);
      do_xfer(1'b1, UART_BAUD_ADDR, 32'h1234, 1, 32'h0, 1'b1, 0);
      do_xfer(1'b0, UART_PARITY_ADDR, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 5);
      do_xfer(1'b1, UART_DATA_ADDR, 32'h55, 0, 32'h0, 1'b0, 5);

      for (int t = 0; t < 20; t++)
         do_xfer(1'($urandom), 10'($urandom), $urandom, int'($urandom_range(0, 4)),
                 $urandom, 1'($urandom), int'($urandom_range(0, 3)));

      do_xfer(1'b0, UART_INT_ADDR, 32'h0, TMO_CYC - 1, 32'h0F0F_0F0F, 1'b0, 1);
      do_xfer(1'b0, UART_INT_ADDR, 32'h0, TMO_CYC, 32'h1111_2222, 1'b0, 1);
      do_xfer(1'b1, UART_CTRL_ADDR, 32'h77, 1000, 32'h0, 1'b1, 0);

      // Reset asserted between edges while a transfer sits in ACCESS
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = UART_DATA_ADDR;
      PREADY    = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      PREADY    = 1'b0;
      @(negedge PCLK);
      chk("pre_reset_access", {PSEL, PENABLE}, 64'(2'b11));
      #1 PRESET = 1'b1;
      #1;
      chk("async_reset_drop", {PSEL, PENABLE, rsp_valid, cmd_ready}, 64'(0));
      #1 PRESET = 1'b0;
      #1;
      chk("ready_after_mid_reset", 64'(cmd_ready), 64'(1));
      @(negedge PCLK);
      chk("no_rsp_after_reset", {rsp_valid, PSEL, cmd_ready}, 64'(3'b001));
      $display("reset mid-ACCESS: transfer discarded, master idle");
      do_xfer(1'b0, uart_reg_addr(10'd1, UART_DATA_ADDR), 32'h0, 0, 32'hCAFE_0008, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
